// File: rtl/id_inst_queue_pkg.sv
// Shared defaults for the IF->ID instruction queue.
package id_inst_queue_pkg;

  localparam int IQ_DEPTH  = 4;
  localparam int IQ_PC_W   = 32;
  localparam int IQ_INST_W = 32;

endpackage

// File: rtl/id_inst_queue.sv
// IF->ID instruction FIFO; 1-cycle push-to-head (0 cycles via empty bypass when BYPASS=1).
// if_ready depends only on registered occupancy; a full queue refuses pushes even when ID pops that cycle.
module id_inst_queue
  import id_inst_queue_pkg::*;
#(
  parameter int DEPTH  = IQ_DEPTH,
  parameter int PC_W   = IQ_PC_W,
  parameter int INST_W = IQ_INST_W,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     if_valid,
  input  logic [PC_W-1:0]          if_pc,
  input  logic [INST_W-1:0]        if_inst,
  output logic                     if_ready,
  output logic                     id_valid,
  output logic [PC_W-1:0]          id_pc,
  output logic [INST_W-1:0]        id_inst,
  input  logic                     id_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          bypass_path;
  logic          push;
  logic          pop;
  logic          push_written;
  logic          pop_from_queue;

  assign empty       = (count == '0);
  assign if_ready    = (count < CW'(DEPTH));
  assign bypass_path = (BYPASS != 0) && empty;

  // rst gates id_valid so ID sees a bubble for the whole reset window.
  always_comb begin
    head     = mem[rd_ptr];
    id_valid = 1'b0;
    if (bypass_path) begin
      head.pc   = if_pc;
      head.inst = if_inst;
    end
    if (rst && !flush) begin
      id_valid = bypass_path ? if_valid : !empty;
    end
    id_pc   = id_valid ? head.pc   : '0;
    id_inst = id_valid ? head.inst : '0;
  end

  assign push           = if_valid && if_ready && !flush;
  assign pop            = id_valid && id_ready && !flush;
  assign pop_from_queue = pop && !empty;
  // A bypassed instruction consumed by ID in the same cycle never touches storage.
  assign push_written   = push && !(bypass_path && pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_written) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_from_queue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push_written) - CW'(pop_from_queue);
    end
  end

  always_ff @(posedge clk) begin
    if (push_written) begin
      mem[wr_ptr] <= '{pc: if_pc, inst: if_inst};
    end
  end

endmodule

// File: tb/tb_id_inst_queue.sv
// Randomized and directed bench for id_inst_queue; one registered-only and one bypass instance share stimulus.
module tb_id_inst_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic        id_ready = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_inst = '0;

  logic        rdy0, vld0, rdy1, vld1;
  logic [31:0] pc0, inst0, pc1, inst1;
  logic [2:0]  cnt0, cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference queues hold {pc, inst}; index 0 is the instruction ID sees next.
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  always #5 clk = ~clk;

  id_inst_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32), .BYPASS(0)) u_reg (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_pc(if_pc),
    .if_inst(if_inst), .if_ready(rdy0), .id_valid(vld0), .id_pc(pc0),
    .id_inst(inst0), .id_ready(id_ready), .count(cnt0)
  );

  id_inst_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_pc(if_pc),
    .if_inst(if_inst), .if_ready(rdy1), .id_valid(vld1), .id_pc(pc1),
    .id_inst(inst1), .id_ready(id_ready), .count(cnt1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_port(input string pfx, input bit byp, input int sz, input logic [63:0] head,
                            input logic v, input logic r, input logic [31:0] pc,
                            input logic [31:0] ins, input logic [2:0] cnt);
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eins;
    ev = 1'b0;
    epc = '0;
    eins = '0;
    if (!flush) begin
      if (sz > 0) begin
        ev = 1'b1; epc = head[63:32]; eins = head[31:0];
      end else if (byp && if_valid) begin
        ev = 1'b1; epc = if_pc; eins = if_inst;
      end
    end
    check({pfx, ".id_valid"}, 64'(v), 64'(ev));
    check({pfx, ".id_pc"}, 64'(pc), 64'(epc));
    check({pfx, ".id_inst"}, 64'(ins), 64'(eins));
    check({pfx, ".if_ready"}, 64'(r), 64'(sz < DEPTH));
    check({pfx, ".count"}, 64'(cnt), 64'(sz));
  endtask

  // Called just after a falling edge: drive, check combinational outputs, advance one cycle.
  task automatic step(input logic fl, input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                      input logic ir);
    int s0;
    int s1;
    flush = fl; if_valid = iv; if_pc = pc; if_inst = ins; id_ready = ir;
    #1;
    s0 = q0.size();
    s1 = q1.size();
    check_port("reg", 1'b0, s0, (s0 > 0) ? q0[0] : 64'h0, vld0, rdy0, pc0, inst0, cnt0);
    check_port("byp", 1'b1, s1, (s1 > 0) ? q1[0] : 64'h0, vld1, rdy1, pc1, inst1, cnt1);
    if (fl) begin
      q0.delete();
      q1.delete();
    end else begin
      if (ir && s0 > 0) void'(q0.pop_front());
      if (iv && s0 < DEPTH) q0.push_back({pc, ins});
      if (ir && s1 > 0) void'(q1.pop_front());
      // An empty bypass queue hands the instruction straight to a ready ID.
      if (iv && s1 < DEPTH && !(s1 == 0 && ir)) q1.push_back({pc, ins});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic async_reset();
    flush = 1'b0; if_valid = 1'b1; if_pc = 32'hdead0000; if_inst = 32'h1; id_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("arst.reg.count", 64'(cnt0), 64'd0);
    check("arst.byp.count", 64'(cnt1), 64'd0);
    check("arst.reg.id_valid", 64'(vld0), 64'd0);
    check("arst.byp.id_valid", 64'(vld1), 64'd0);
    check("arst.byp.id_pc", 64'(pc1), 64'd0);
    check("arst.byp.if_ready", 64'(rdy1), 64'd1);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    check("arst.hold.reg.count", 64'(cnt0), 64'd0);
    @(negedge clk);
    if_valid = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    // Reset state, with fetch offering an instruction that must not leak through.
    if_valid = 1'b1; if_pc = 32'h44; if_inst = 32'h55;
    #1;
    check("rst.reg.id_valid", 64'(vld0), 64'd0);
    check("rst.byp.id_valid", 64'(vld1), 64'd0);
    check("rst.byp.id_pc", 64'(pc1), 64'd0);
    check("rst.byp.id_inst", 64'(inst1), 64'd0);
    check("rst.reg.count", 64'(cnt0), 64'd0);
    check("rst.reg.if_ready", 64'(rdy0), 64'd1);
    @(negedge clk);
    @(negedge clk);
    if_valid = 1'b0;
    rst = 1'b1;
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // Fill to full with ID stalled, try a push into a full queue with a pop, then drain.
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 32'(4 * k), 32'(32'hA000 + k), 1'b0);
    check("fill.reg.count", 64'(cnt0), 64'd4);
    check("fill.reg.if_ready", 64'(rdy0), 64'd0);
    check("fill.reg.head", 64'(pc0), 64'h0);
    step(1'b0, 1'b1, 32'h10, 32'hBEEF, 1'b0);
    step(1'b0, 1'b1, 32'h14, 32'hBEEF, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check("drain.reg.count", 64'(cnt0), 64'd0);

    // Steady push+pop across two pointer wraps.
    step(1'b0, 1'b1, 32'h100, 32'hC000, 1'b0);
    for (int k = 1; k < 10; k++) begin
      step(1'b0, 1'b1, 32'(32'h100 + 4 * k), 32'(32'hC000 + k), 1'b1);
      check("wrap.reg.count", 64'(cnt0), 64'd1);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Empty-queue pass-through.
    flush = 1'b0; if_valid = 1'b1; if_pc = 32'h20; if_inst = 32'h1234; id_ready = 1'b1;
    #1;
    check("bypass.byp.id_valid", 64'(vld1), 64'd1);
    check("bypass.byp.id_pc", 64'(pc1), 64'h20);
    step(1'b0, 1'b1, 32'h20, 32'h1234, 1'b1);
    check("bypass.byp.count", 64'(cnt1), 64'd0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Flush drops queued entries and the instruction offered in the flush cycle.
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 32'(32'h200 + 4 * k), 32'(k), 1'b0);
    step(1'b1, 1'b1, 32'h300, 32'h9, 1'b0);
    check("flush.reg.count", 64'(cnt0), 64'd0);
    check("flush.byp.count", 64'(cnt1), 64'd0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Asynchronous reset with two entries queued.
    step(1'b0, 1'b1, 32'h400, 32'h1, 1'b0);
    step(1'b0, 1'b1, 32'h404, 32'h2, 1'b0);
    check("arst.pre.count", 64'(cnt0), 64'd2);
    async_reset();
    step(1'b0, 1'b1, 32'h500, 32'h77, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        step($urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7, $urandom, $urandom,
             $urandom_range(0, 9) < 6);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
